packet_fifo: RTL
================

// Module: packet_fifo
// PURPOSE
//  Frame-aware synchronous FIFO for switch port ingress/egress queues: stores WIDTH-bit words plus an end-of-frame flag.
//  Words of a frame become readable only once its last word is written (commit), so partial frames never reach the reader.
//  A frame can be discarded mid-write (bad FCS, abort) or is discarded automatically on overflow, by rewinding the write pointer.
// PARAMETERS
//  WIDTH        8   data word width in bits
//  DEPTH        16  storage words; must be a power of 2, >= 2
//  ALMOST_FULL  12  almost_full asserts when occupancy (incl. uncommitted words) >= ALMOST_FULL; 1..DEPTH
// PORTS
//  clock         input   1                  rising-edge clock
//  reset_n       input   1                  asynchronous reset, active low
//  write_data    input   WIDTH              word to store
//  write_last    input   1                  write_data is the final word of its frame
//  write_enable  input   1                  write request
//  write_abort   input   1                  discard the frame currently being written
//  read_enable   input   1                  read request
//  read_data     output  WIDTH              registered read word
//  read_last     output  1                  read_data is the final word of its frame
//  read_valid    output  1                  read_data/read_last updated this cycle
//  is_empty      output  1                  no committed word available
//  is_full       output  1                  all DEPTH words in use (committed + uncommitted)
//  almost_full   output  1                  occupancy >= ALMOST_FULL
//  level         output  $clog2(DEPTH)+1    committed words available to read
//  drop_pulse    output  1                  1-cycle pulse: a frame was discarded
// BEHAVIOUR
//  Pointers write_offset, commit_offset, read_offset: $clog2(DEPTH)+1 bits each; MSB is the wrap bit, low bits address storage.
//  Storage is an internal array of {last, data}, DEPTH entries, no reset.
//  occupancy = write_offset - read_offset (mod 2^(n+1)); is_full = (occupancy == DEPTH); almost_full = (occupancy >= ALMOST_FULL).
//  level = commit_offset - read_offset; is_empty = (commit_offset == read_offset). All flags are combinational from the pointers.
//  Write accepted = write_enable & ~is_full & ~overflow & ~write_abort: store {write_last, write_data} at write_offset; write_offset += 1.
//   If the accepted word has write_last: commit_offset <= write_offset + 1 in the same clock edge; the frame is readable next cycle.
//  Overflow: write_enable & is_full & ~write_abort sets internal overflow flag; the word is not stored.
//   While overflow: all writes are discarded; a write_enable with write_last ends the frame: write_offset <= commit_offset,
//   overflow <= 0, drop_pulse <= 1 for one cycle. A frame longer than DEPTH therefore always drops.
//  Abort: write_abort (regardless of write_enable) -> write_offset <= commit_offset, overflow <= 0, drop_pulse <= 1;
//   abort has priority over a same-cycle write, which is discarded. Abort with no uncommitted words still pulses drop_pulse.
//  Read accepted = read_enable & ~is_empty: next edge read_data/read_last <= entry at read_offset, read_offset += 1,
//   read_valid <= 1. Read latency 1 cycle. Otherwise read_valid <= 0 and read_data/read_last hold their value.
//   read_enable while is_empty is ignored (no pointer change, read_valid 0).
//  Simultaneous accepted read and write/commit/abort are all legal in one cycle; rewind never touches committed words.
//  Pointers wrap naturally mod 2^(n+1); full/empty distinguished by the wrap bit.
//  Reset (async assert, sync release): all pointers 0, overflow 0, read_data 0, read_last 0, read_valid 0, drop_pulse 0;
//   hence is_empty 1, is_full 0, almost_full 0, level 0. Reset mid-frame loses the partial frame and all stored frames.
// TESTING
//  1. After reset: is_empty=1, is_full=0, level=0, read_valid=0; read_enable for 3 cycles -> read_valid stays 0, pointers unchanged.
//  2. DEPTH=16: write 0x11,0x22,0x33(last) -> is_empty=1 until the cycle after 0x33; then level=3; 3 reads return
//     0x11,0x22,0x33 one cycle after each read_enable, read_last=1 only on 0x33, then is_empty=1.
//  3. Write 4 words without last, then write_abort -> drop_pulse=1 for 1 cycle, level=0, occupancy 0; next 2-word frame reads back intact.
//  4. Commit 10-word frame, then write 8-word frame (last on word 8): words 7,8 hit is_full -> overflow; last word -> drop_pulse,
//     level stays 10, is_full=0; reading returns only the 10-word frame.
//  5. Wrap: 6 rounds of 5-word frames written and read concurrently (read while writing) -> all 30 words in order, no drop,
//     almost_full asserts exactly when occupancy reaches 12.
//  6. Assert reset_n low mid-frame with 2 committed frames stored -> outputs at reset values immediately (asynchronously); after release is_empty=1.

Source files
------------

// File: rtl/packet_fifo.sv
// packet_fifo: frame-aware synchronous FIFO.
// Each entry holds {last, data}. A frame only becomes visible to the reader
// when its last word is written (commit pointer advances). An uncommitted
// frame is discarded on abort or overflow by rewinding the write pointer to
// the commit pointer, so committed words are never disturbed.
module packet_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     write_last,
  input  logic                     write_enable,
  input  logic                     write_abort,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_last,
  output logic                     read_valid,
  output logic                     is_empty,
  output logic                     is_full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_AF    = (AW+1)'(ALMOST_FULL);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      cm_ptr_q, cm_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rlast_q, rlast_d;
  logic             rvalid_q, rvalid_d;

  // Storage is deliberately not reset; the pointers define what is valid.
  logic [WIDTH:0]   mem_q [DEPTH];

  logic [AW:0]      occupancy;
  logic             wr_accept;
  logic             rd_accept;

  // Flags derived purely from the pointers; occupancy includes uncommitted words.
  always_comb begin
    occupancy   = wr_ptr_q - rd_ptr_q;
    is_full     = (occupancy == PTR_DEPTH);
    almost_full = (occupancy >= PTR_AF);
    level       = cm_ptr_q - rd_ptr_q;
    is_empty    = (cm_ptr_q == rd_ptr_q);
  end

  // Write side: accept, commit on last word, or rewind on abort/overflow end.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    ovf_d     = ovf_q;
    drop_d    = 1'b0;
    wr_accept = 1'b0;
    if (write_abort) begin
      // Abort wins over any same-cycle write.
      wr_ptr_d = cm_ptr_q;
      ovf_d    = 1'b0;
      drop_d   = 1'b1;
    end else if (write_enable) begin
      if (ovf_q || is_full) begin
        // Frame cannot fit: swallow words until its last one, then rewind.
        if (write_last) begin
          wr_ptr_d = cm_ptr_q;
          ovf_d    = 1'b0;
          drop_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        wr_accept = 1'b1;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        if (write_last) begin
          cm_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end
    end
  end

  // Read side: one-cycle latency registered output, held when idle.
  always_comb begin
    rd_accept = read_enable & ~is_empty;
    rd_ptr_d  = rd_ptr_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rvalid_d  = 1'b0;
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_ptr_q[AW-1:0]][WIDTH-1:0];
      rlast_d  = mem_q[rd_ptr_q[AW-1:0]][WIDTH];
      rvalid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {write_last, write_data};
    end
  end

  assign read_data  = rdata_q;
  assign read_last  = rlast_q;
  assign read_valid = rvalid_q;
  assign drop_pulse = drop_q;

endmodule
